// File: rtl/processor_mem_arbiter.sv
// Arbiter that shares one single-port synchronous RAM between instruction fetch and data access.
// Data wins by default. A starvation counter forces a fetch grant, and read data returns tagged one cycle later.
module processor_mem_arbiter #(
    parameter int ADDR_SIZE    = 18,
    parameter int WORD_SIZE    = 18,
    parameter int STARVE_LIMIT = 3,
    parameter int STARVE_W     = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic [ADDR_SIZE-1:0] fetch_addr,
    output logic                 fetch_grant,
    output logic                 fetch_rvalid,
    output logic [WORD_SIZE-1:0] fetch_rdata,
    input  logic                 data_req,
    input  logic                 data_we,
    input  logic [ADDR_SIZE-1:0] data_addr,
    input  logic [WORD_SIZE-1:0] data_wdata,
    output logic                 data_grant,
    output logic                 data_rvalid,
    output logic [WORD_SIZE-1:0] data_rdata,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    output logic                 fetch_stall,
    output logic                 data_stall
);

    typedef enum logic [1:0] {
        TAG_NONE  = 2'd0,
        TAG_FETCH = 2'd1,
        TAG_DREAD = 2'd2
    } tag_t;

    tag_t                 r_tag;
    tag_t                 w_tag_next;
    logic [STARVE_W-1:0]  r_starve_cnt;
    logic [ADDR_SIZE-1:0] r_mem_addr;
    logic                 w_force_fetch;

    assign w_force_fetch = (STARVE_LIMIT != 0) && (r_starve_cnt == STARVE_W'(STARVE_LIMIT));

    // Fetch only wins a contended cycle when forced; otherwise data owns the port.
    assign fetch_grant = !reset && fetch_req && (!data_req || w_force_fetch);
    assign data_grant  = !reset && data_req && !(fetch_req && w_force_fetch);

    assign fetch_stall = fetch_req && !fetch_grant;
    assign data_stall  = data_req && !data_grant;

    always_comb begin
        mem_addr  = r_mem_addr;
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (data_grant) begin
            mem_addr  = data_addr;
            mem_we    = data_we;
            mem_wdata = data_wdata;
        end else if (fetch_grant) begin
            mem_addr  = fetch_addr;
        end
    end

    always_comb begin
        w_tag_next = TAG_NONE;
        if (fetch_grant)
            w_tag_next = TAG_FETCH;
        else if (data_grant && !data_we)
            w_tag_next = TAG_DREAD;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_tag        <= TAG_NONE;
            r_starve_cnt <= '0;
            r_mem_addr   <= '0;
        end else begin
            r_tag <= w_tag_next;
            if (fetch_grant || data_grant)
                r_mem_addr <= mem_addr;
            if (!fetch_req || fetch_grant)
                r_starve_cnt <= '0;
            else if (r_starve_cnt != STARVE_W'(STARVE_LIMIT))
                r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign fetch_rvalid = !reset && (r_tag == TAG_FETCH);
    assign data_rvalid  = !reset && (r_tag == TAG_DREAD);
    assign fetch_rdata  = mem_rdata;
    assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_processor_mem_arbiter.sv
// Randomized and directed checks of processor_mem_arbiter against a cycle-level model of the arbitration rules.
// A second instance with starvation protection disabled runs alongside the main one.
module tb_processor_mem_arbiter;
    localparam int LIMIT = 3;

    logic        clock = 1'b0;
    logic        reset;
    logic        fetch_req, data_req, data_we;
    logic [17:0] fetch_addr, data_addr, data_wdata;
    logic        fetch_grant, fetch_rvalid, data_grant, data_rvalid, mem_we;
    logic        fetch_stall, data_stall;
    logic [17:0] fetch_rdata, data_rdata, mem_addr, mem_wdata;
    logic [17:0] mem_rdata;

    logic        z_fgrant, z_frv, z_dgrant, z_drv, z_we, z_fst, z_dst;
    logic [17:0] z_frd, z_drd, z_addr, z_wd;

    int total = 0;
    int bad = 0;

    always #5 clock = ~clock;

    processor_mem_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .STARVE_LIMIT(LIMIT), .STARVE_W(4)) dut (
        .clock(clock), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_grant(fetch_grant),
        .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_grant(data_grant), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .fetch_stall(fetch_stall), .data_stall(data_stall)
    );

    processor_mem_arbiter #(.ADDR_SIZE(18), .WORD_SIZE(18), .STARVE_LIMIT(0), .STARVE_W(4)) u_nostarve (
        .clock(clock), .reset(reset),
        .fetch_req(1'b1), .fetch_addr(18'h00006), .fetch_grant(z_fgrant),
        .fetch_rvalid(z_frv), .fetch_rdata(z_frd),
        .data_req(1'b1), .data_we(1'b0), .data_addr(18'h00005), .data_wdata(18'h0),
        .data_grant(z_dgrant), .data_rvalid(z_drv), .data_rdata(z_drd),
        .mem_addr(z_addr), .mem_we(z_we), .mem_wdata(z_wd), .mem_rdata(18'h0),
        .fetch_stall(z_fst), .data_stall(z_dst)
    );

    function automatic logic [17:0] init_val(input logic [17:0] a);
        case (a)
            18'h00010: return 18'h001A5;
            18'h00011: return 18'h002B6;
            18'h00012: return 18'h003C7;
            18'h00005: return 18'h11111;
            18'h00006: return 18'h22222;
            default:   return {a[8:0] ^ 9'h155, a[8:0]};
        endcase
    endfunction

    // RAM environment: write-first, registered read
    logic [17:0] ram [logic [17:0]];
    always @(posedge clock) begin
        if (mem_we) begin
            ram[mem_addr] = mem_wdata;
            mem_rdata <= mem_wdata;
        end else begin
            mem_rdata <= ram.exists(mem_addr) ? ram[mem_addr] : init_val(mem_addr);
        end
    end

    // Reference model state
    logic [17:0] ref_mem [logic [17:0]];
    int          streak = 0;
    int          pend_side = 0;     // 0 none, 1 fetch, 2 data read
    logic [17:0] pend_data = '0;
    logic [17:0] last_addr = '0;
    int          dut_fgrants = 0;

    function automatic logic [17:0] ref_rd(input logic [17:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic rst, input logic fr, input logic [17:0] fa,
                       input logic dr, input logic dwe, input logic [17:0] da, input logic [17:0] dwd);
        logic eg_f, eg_d, force_f;
        @(negedge clock);
        reset = rst; fetch_req = fr; fetch_addr = fa;
        data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
        #1;
        force_f = (LIMIT != 0) && (streak >= LIMIT);
        if (rst) begin
            eg_f = 1'b0; eg_d = 1'b0;
        end else if (fr && dr) begin
            eg_f = force_f; eg_d = !force_f;
        end else begin
            eg_f = fr; eg_d = dr;
        end
        dut_fgrants += int'(fetch_grant);
        chk("fetch_grant", 32'(fetch_grant), 32'(eg_f));
        chk("data_grant", 32'(data_grant), 32'(eg_d));
        chk("grant_excl", 32'(fetch_grant & data_grant), 32'd0);
        chk("fetch_stall", 32'(fetch_stall), 32'(fr & !eg_f));
        chk("data_stall", 32'(data_stall), 32'(dr & !eg_d));
        chk("mem_we", 32'(mem_we), 32'(eg_d & dwe));
        if (!rst)
            chk("mem_addr", 32'(mem_addr), 32'(eg_d ? da : (eg_f ? fa : last_addr)));
        if (!eg_f)
            chk("mem_wdata", 32'(mem_wdata), 32'(eg_d ? dwd : 18'h0));
        chk("fetch_rvalid", 32'(fetch_rvalid), 32'(!rst && pend_side == 1));
        chk("data_rvalid", 32'(data_rvalid), 32'(!rst && pend_side == 2));
        if (!rst && pend_side == 1) chk("fetch_rdata", 32'(fetch_rdata), 32'(pend_data));
        if (!rst && pend_side == 2) chk("data_rdata", 32'(data_rdata), 32'(pend_data));
        chk("nostarve_fgrant", 32'(z_fgrant), 32'd0);
        chk("nostarve_dgrant", 32'(z_dgrant), 32'(!rst));
        // advance model across the coming clock edge
        if (rst) begin
            streak = 0; pend_side = 0; last_addr = '0;
        end else begin
            if (!fr || eg_f) streak = 0;
            else if (streak < LIMIT) streak++;
            if (eg_d) last_addr = da;
            else if (eg_f) last_addr = fa;
            pend_side = 0;
            if (eg_f) begin
                pend_side = 1; pend_data = ref_rd(fa);
            end else if (eg_d && !dwe) begin
                pend_side = 2; pend_data = ref_rd(da);
            end else if (eg_d && dwe) begin
                ref_mem[da] = dwd;
            end
        end
    endtask

    initial begin
        reset = 1'b1; fetch_req = 1'b0; data_req = 1'b0; data_we = 1'b0;
        fetch_addr = '0; data_addr = '0; data_wdata = '0;

        // Reset held with both requests asserted
        cyc(1, 1, 18'h00001, 1, 0, 18'h00002, 18'h0);
        cyc(1, 1, 18'h00001, 1, 0, 18'h00002, 18'h0);
        cyc(0, 1, 18'h00001, 1, 0, 18'h00002, 18'h0);
        chk("post_reset_data_first", 32'(dut_fgrants), 32'd0);
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);

        // Fetch stream
        cyc(0, 1, 18'h00010, 0, 0, 18'h0, 18'h0);
        cyc(0, 1, 18'h00011, 0, 0, 18'h0, 18'h0);
        cyc(0, 1, 18'h00012, 0, 0, 18'h0, 18'h0);
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);

        // Contention: three periods of d,d,d,f
        dut_fgrants = 0;
        for (int i = 0; i < 12; i++)
            cyc(0, 1, 18'h00006, 1, 0, 18'h00005, 18'h0);
        chk("starve_period_fgrants", 32'(dut_fgrants), 32'd3);
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);

        // Write then read same address
        cyc(0, 0, 18'h0, 1, 1, 18'h00100, 18'h2AAAA);
        cyc(0, 0, 18'h0, 1, 0, 18'h00100, 18'h0);
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);

        // Interleaved read tags
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 18'h0, 1, 0, 18'h00005, 18'h0);
            cyc(0, 1, 18'h00006, 0, 0, 18'h0, 18'h0);
        end
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);

        // Reset right after a data read grant
        cyc(0, 0, 18'h0, 1, 0, 18'h00005, 18'h0);
        cyc(1, 1, 18'h00006, 1, 1, 18'h00005, 18'h3FFFF);
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);

        // Random traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 49) == 0),
                1'($urandom_range(0, 1)), 18'($urandom_range(0, 15)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                18'($urandom_range(0, 15)), 18'($urandom));
        end
        cyc(0, 0, 18'h0, 0, 0, 18'h0, 18'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/processor_mem_arbiter.md
Name: processor_mem_arbiter

Overview:
Shares one single-port synchronous RAM between instruction fetch (stage 1) and data load/store (stage 3). Grants one requester per cycle. Data accesses win by default. A starvation counter forces a fetch grant after a bounded number of denied cycles. Read data returns one cycle after grant, tagged to the owning requester; the ungranted side sees a stall.

Parameters:
ADDR_SIZE, 18, address width
WORD_SIZE, 18, data word width
STARVE_LIMIT, 3, consecutive denied fetch cycles before fetch is forced to win; 0 = protection disabled (data always wins)
STARVE_W, 4, starvation counter width; must satisfy STARVE_LIMIT < 2**STARVE_W

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
fetch_req  input  1  fetch read request, held until granted
fetch_addr  input  ADDR_SIZE  fetch address (ip)
fetch_grant  output  1  fetch accepted this cycle (combinational)
fetch_rvalid  output  1  fetch_rdata valid this cycle
fetch_rdata  output  WORD_SIZE  fetched code word
data_req  input  1  data access request, held until granted
data_we  input  1  1 = write, 0 = read
data_addr  input  ADDR_SIZE  data address (ry+imm8)
data_wdata  input  WORD_SIZE  store data (rx)
data_grant  output  1  data accepted this cycle (combinational)
data_rvalid  output  1  data_rdata valid this cycle (reads only)
data_rdata  output  WORD_SIZE  load result
mem_addr  output  ADDR_SIZE  RAM address
mem_we  output  1  RAM write enable
mem_wdata  output  WORD_SIZE  RAM write data
mem_rdata  input  WORD_SIZE  RAM read data, registered by RAM, valid the cycle after the address
fetch_stall  output  1  fetch_req & !fetch_grant
data_stall  output  1  data_req & !data_grant

Behaviour:
- One clock; reset is synchronous and active-high. All state updates occur on posedge clock.
- Grant logic is combinational and evaluated every cycle:
  - force_fetch = (STARVE_LIMIT != 0) & (starve_cnt == STARVE_LIMIT).
  - Only fetch_req: fetch_grant=1.
  - Only data_req: data_grant=1.
  - Both requests: fetch_grant = force_fetch; data_grant = !force_fetch.
  - Never both grants in the same cycle.
- RAM drive:
  - Data granted: mem_addr=data_addr, mem_we=data_we, mem_wdata=data_wdata.
  - Fetch granted: mem_addr=fetch_addr, mem_we=0.
  - No grant: mem_we=0, mem_addr holds its last registered value, mem_wdata=0.
  - mem_we must never be 1 outside a data write grant.
- Response tracking is a registered tag with states NONE, FETCH, DREAD:
  - Next tag = FETCH on fetch grant, DREAD on data read grant, NONE otherwise (including data writes).
  - fetch_rvalid = (tag==FETCH); data_rvalid = (tag==DREAD).
  - fetch_rdata = data_rdata = mem_rdata, passed through combinationally. Only the side with rvalid may consume it.
- Latency:
  - Read: grant in cycle N, rvalid and data in cycle N+1.
  - Write: committed at the posedge ending cycle N; no response.
  - Back-to-back grants are allowed every cycle, so throughput is 1 access/cycle.
- starve_cnt update:
  - Cleared when fetch_req=0 or fetch_grant=1.
  - Incremented when fetch_req=1 and fetch_grant=0, saturating at STARVE_LIMIT.
- Write-then-read to the same address on consecutive grants returns the new value (RAM write-first). The arbiter adds no forwarding.
- Request dropped before grant: legal and ignored. Address/data changes while ungranted are legal; the values sampled in the grant cycle are used.
- Reset, including mid-operation:
  - tag=NONE, starve_cnt=0, registered mem_addr=0.
  - During and after reset: fetch_rvalid=0, data_rvalid=0, mem_we=0, and both grants are 0 while reset=1.
  - A read granted in the cycle before reset asserts produces no rvalid.

Test Plan:
- Reset: hold reset 2 cycles with both requests high -> no grants, mem_we=0, rvalids 0. After release the first grant goes to data (starve_cnt=0).
- Fetch only: fetch_req with addresses 0x00010, 0x00011, 0x00012 on consecutive cycles, RAM preloaded 0x1A5, 0x2B6, 0x3C7 -> grants each cycle; fetch_rvalid one cycle later with data in order; data_rvalid stays 0.
- Contention/starvation, STARVE_LIMIT=3: both requests held continuously -> grant pattern data,data,data,fetch repeating. fetch_stall=1 for exactly 3 cycles per period. Repeat with STARVE_LIMIT=0 -> fetch never granted.
- Write-then-read: data write 0x2AAAA to address 0x00100, then data read of 0x00100 next cycle -> mem_we=1 only in the write cycle, no rvalid for the write; data_rvalid=1 with data_rdata=0x2AAAA two cycles after the write grant.
- Interleaved read tags: alternate data read 0x00005 and fetch 0x00006 (mem 0x11111/0x22222) -> data_rvalid and fetch_rvalid alternate, each carrying its own word, never both high.
- Reset mid-read: grant a data read, assert reset the next cycle -> data_rvalid stays 0, starve_cnt=0, mem_we=0 throughout.
